// File: rtl/start_req_queue.sv
// start_req_queue: request FIFO feeding the IDLE/LOAD/DONE load controller.
// Stores payload words and, for each one, issues a single-cycle start pulse
// while the controller is IDLE. It then follows the transaction through LOAD
// and DONE before it issues the next request. An ACK timeout or a controller
// reset during RUN sets the sticky abort flag.
module start_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [DATA_W-1:0]      req_data,
  output logic                   req_ready,
  input  logic [1:0]             fsm_state,
  output logic                   start,
  output logic [DATA_W-1:0]      load_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt,
  output logic                   abort
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] CTL_IDLE = 2'b00;
  localparam logic [1:0] CTL_LOAD = 2'b01;
  localparam logic [1:0] CTL_DONE = 2'b10;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ACK  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        ack_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic push;
  logic drop;
  logic issue;

  // Readiness depends only on the occupancy before the edge. A full FIFO
  // therefore refuses an offer even when a pop happens at the same edge.
  assign req_ready = (count != CW'(DEPTH));
  assign push      = req_valid && req_ready;
  assign drop      = req_valid && !req_ready;
  assign issue     = (state == S_WAIT) && (count != '0) && (fsm_state == CTL_IDLE);
  assign busy      = (state != S_WAIT);

  // Payload storage, written on accepted offers.
  // NOTE: the storage array has no reset. Its contents are don't-care once the pointers and count are cleared, and leaving it unreset allows a plain RAM to be used.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_data;
  end

  // Pointers, occupancy and refused-offer counter. A push and a pop at the same edge leave the occupancy unchanged.
  // NOTE: every register uses non-blocking assignment, so each always_ff reads the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Issue FSM (WAIT -> ACK -> RUN -> WAIT) with registered start, load_data and abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_WAIT;
      ack_cnt   <= '0;
      start     <= 1'b0;
      load_data <= '0;
      abort     <= 1'b0;
    end else begin
      // start is high only for the cycle after an issue edge.
      start <= issue;
      case (state)
        S_WAIT: begin
          if (issue) begin
            load_data <= mem[rd_ptr];
            ack_cnt   <= '0;
            state     <= S_ACK;
          end
        end
        S_ACK: begin
          if (fsm_state == CTL_LOAD) begin
            state <= S_RUN;
          end else if (ack_cnt == 2'd3) begin
            // This is the fourth edge without LOAD. The popped entry is discarded.
            state <= S_WAIT;
            abort <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (fsm_state == CTL_DONE) begin
            state <= S_WAIT;
          end else if (fsm_state == CTL_IDLE) begin
            // The controller returned to IDLE without passing through DONE.
            state <= S_WAIT;
            abort <= 1'b1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_start_req_queue.sv
// tb_start_req_queue: scoreboard bench for start_req_queue. Accepted payloads
// are queued when they are offered. They are popped and compared against
// load_data each time start is seen. A small controller model (IDLE -> LOAD ->
// DONE) can drive fsm_state, or the bench can force fsm_state to a fixed value.
module tb_start_req_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_data;
  logic       req_ready;
  logic [1:0] fsm_state;
  logic       start;
  logic [7:0] load_data;
  logic       busy;
  logic [2:0] count;
  logic [7:0] drop_cnt;
  logic       abort;

  logic       ctrl_auto;
  logic [1:0] fsm_force;
  logic [1:0] ctrl_q;

  logic [7:0] sb[$];
  int         start_times[$];
  logic [7:0] last_exp;
  int         cyc;
  int         n_checks;
  int         n_errors;

  start_req_queue #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fsm_state (fsm_state),
    .start     (start),
    .load_data (load_data),
    .busy      (busy),
    .count     (count),
    .drop_cnt  (drop_cnt),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: it leaves IDLE when it samples start, then spends one cycle each in LOAD and DONE.
  always @(posedge clk) begin
    if (!ctrl_auto) ctrl_q <= 2'b00;
    else begin
      case (ctrl_q)
        2'b00:   if (start) ctrl_q <= 2'b01;
        2'b01:   ctrl_q <= 2'b10;
        default: ctrl_q <= 2'b00;
      endcase
    end
  end

  assign fsm_state = ctrl_auto ? ctrl_q : fsm_force;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic prev_start = 1'b0;
  always @(posedge clk) begin
    #1;
    if (start) begin
      start_times.push_back(cyc);
      if (prev_start) check("start_width", 1, 0);
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        last_exp = sb.pop_front();
        check("issue_data", int'(load_data), int'(last_exp));
      end
    end
    if (ctrl_auto && fsm_state == 2'b01)
      check("load_data_in_load", int'(load_data), int'(last_exp));
    prev_start = start;
  end

  task automatic offer(input logic [7:0] d, input bit accept);
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = d;
    if (accept) sb.push_back(d);
  endtask

  task automatic idle_in;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    last_exp = 8'h00;
    reset = 1'b1;
    req_valid = 1'b0;
    req_data = 8'h00;
    ctrl_auto = 1'b0;
    fsm_force = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_start", int'(start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_load_data", int'(load_data), 0);
    check("rst_drop", int'(drop_cnt), 0);
    check("rst_abort", int'(abort), 0);

    // Back-to-back issue with the controller model driving fsm_state
    ctrl_auto = 1'b1;
    start_times.delete();
    offer(8'hA1, 1);
    offer(8'hB2, 1);
    offer(8'hC3, 1);
    idle_in();
    repeat (14) @(negedge clk);
    check("b2b_starts", start_times.size(), 3);
    if (start_times.size() == 3) begin
      check("b2b_gap1", start_times[1] - start_times[0], 4);
      check("b2b_gap2", start_times[2] - start_times[1], 4);
    end
    check("b2b_count", int'(count), 0);
    check("b2b_busy", int'(busy), 0);

    // Overflow while the controller is held in LOAD
    ctrl_auto = 1'b0;
    fsm_force = 2'b01;
    start_times.delete();
    offer(8'h11, 1);
    offer(8'h22, 1);
    offer(8'h33, 1);
    offer(8'h44, 1);
    offer(8'h55, 0);
    offer(8'h66, 0);
    idle_in();
    check("ovf_count", int'(count), 4);
    check("ovf_ready", int'(req_ready), 0);
    check("ovf_drop", int'(drop_cnt), 2);
    check("ovf_no_start", start_times.size(), 0);
    // Offer while full at the same edge as the first pop: the offer is refused.
    offer(8'h77, 0);
    ctrl_auto = 1'b1;
    idle_in();
    check("full_pop_count", int'(count), 3);
    check("full_pop_drop", int'(drop_cnt), 3);
    repeat (16) @(negedge clk);
    check("ovf_drain_count", int'(count), 0);
    check("ovf_drain_sb", sb.size(), 0);
    check("ovf_starts", start_times.size(), 4);

    // Simultaneous push and pop with one entry stored
    ctrl_auto = 1'b0;
    fsm_force = 2'b01;
    offer(8'h5A, 1);
    offer(8'h6B, 1);
    ctrl_auto = 1'b1;
    idle_in();
    check("pushpop_count", int'(count), 1);
    repeat (10) @(negedge clk);
    check("pushpop_drain", int'(count), 0);
    check("pushpop_sb", sb.size(), 0);
    check("pre_timeout_abort", int'(abort), 0);

    // ACK timeout: the controller stays IDLE after start
    ctrl_auto = 1'b0;
    fsm_force = 2'b00;
    offer(8'hD4, 1);
    idle_in();
    repeat (4) @(negedge clk);
    check("ack_busy_before", int'(busy), 1);
    check("ack_abort_before", int'(abort), 0);
    @(negedge clk);
    check("ack_busy_after", int'(busy), 0);
    check("ack_abort_after", int'(abort), 1);
    check("ack_count", int'(count), 0);
    ctrl_auto = 1'b1;
    offer(8'hE5, 1);
    idle_in();
    repeat (8) @(negedge clk);
    check("after_timeout_sb", sb.size(), 0);
    check("abort_sticky", int'(abort), 1);

    // Controller reset during RUN, followed by the next issue
    ctrl_auto = 1'b0;
    fsm_force = 2'b00;
    offer(8'hF6, 1);
    offer(8'h07, 1);
    idle_in();
    fsm_force = 2'b01;
    @(negedge clk);
    check("run_busy", int'(busy), 1);
    fsm_force = 2'b00;
    @(negedge clk);
    check("runrst_busy", int'(busy), 0);
    check("runrst_abort", int'(abort), 1);
    check("runrst_no_start", int'(start), 0);
    @(negedge clk);
    check("runrst_next_start", int'(start), 1);
    check("runrst_count", int'(count), 0);
    fsm_force = 2'b01;
    @(negedge clk);
    check("run2_busy", int'(busy), 1);

    // Reset asserted for one cycle while in RUN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    check("midrst_start", int'(start), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_ready", int'(req_ready), 1);
    check("midrst_abort", int'(abort), 0);
    check("midrst_drop", int'(drop_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/start_req_queue.md
# start_req_queue

Upstream feeder for the IDLE/LOAD/DONE load controller. Buffers load requests (payload words) in a small FIFO and issues one single-cycle `start` pulse per request, only when the controller reports IDLE. Presents the issued payload on `load_data` for the controller's LOAD cycle. Tracks each transaction through LOAD and DONE before issuing the next request.

## Interface
- `DATA_W`, 8: payload width.
- `DEPTH`, 4: FIFO entries. Must be a power of 2, ≥2.
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: a request is offered.
- `req_data`  in  DATA_W: request payload.
- `req_ready`  out  1: `!full`, combinational from the occupancy register.
- `fsm_state`  in  2: controller state. 00 IDLE, 01 LOAD, 10 DONE, 11 treated as "not IDLE, not LOAD, not DONE".
- `start`  out  1: registered one-cycle issue pulse to the controller.
- `load_data`  out  DATA_W: registered payload of the most recently issued request.
- `busy`  out  1: high while the issue FSM is not in WAIT.
- `count`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `drop_cnt`  out  8: saturating count of refused offers.
- `abort`  out  1: sticky flag; cleared only by `reset`.

## Operation
- **Push:** an offer is accepted at the edge where `req_valid && req_ready`. The write pointer increments and wraps modulo DEPTH.
- **Refused offer:** `req_valid && !req_ready` increments `drop_cnt`, which saturates at 255.
- **Issue FSM:** states WAIT, ACK, RUN.
- **WAIT:**
  - Condition: `count>0 && fsm_state==00` at an edge.
  - Action at that edge: `start<=1`, `load_data<=` head entry, pop (read pointer +1 with wrap, occupancy −1), go to ACK.
- **ACK:**
  - `start` is forced to 0 at the first edge after entry.
  - `fsm_state==01` at an edge → RUN.
  - Timeout: if 4 edges pass in ACK without seeing 01 → WAIT and set `abort`. The popped entry is discarded, not re-queued.
- **RUN:**
  - `fsm_state==10` → WAIT.
  - `fsm_state==00` without DONE (controller reset mid-transaction) → WAIT and set `abort`.
  - Otherwise stay in RUN.
- **Simultaneous push and pop:** both take effect and occupancy is unchanged.
- **Push when full:** never accepted, even if a pop occurs at the same edge, because `req_ready` comes from the pre-edge occupancy.
- **Push into an empty FIFO:** that entry is issued no earlier than the edge after it was accepted.
- **`load_data`:** changes only at issue edges; held stable otherwise.
- **Reset values:** pointers 0, `count` 0, `req_ready` 1, `start` 0, `load_data` 0, `busy` 0, `drop_cnt` 0, `abort` 0, FSM WAIT. FIFO contents are don't-care.
- **Reset priority:** reset overrides push, pop and issue in the same cycle. Queued entries are flushed.

## Timing
- **Issue latency:** `start` is high in cycle N+1 after the issue edge at the end of cycle N.
- **Controller handoff:** the controller samples `start` at edge N+1 and enters LOAD. This block sees 01 during cycle N+2 and enters RUN at edge N+2.
- **Transaction length:** DONE in cycle N+3 returns this block to WAIT at edge N+3. With `fsm_state==00` in cycle N+4, the next issue can occur at edge N+4.
- **Throughput:** one transaction per 4 cycles back-to-back.
- **Pulse width:** `start` is exactly 1 cycle wide per issue, never wider.
- **Data validity:** `load_data` is valid from cycle N+1 through the controller's LOAD cycle, and until the next issue.
- **Count update:** `count` and `req_ready` update at the same edge as the push or pop.
- **`busy`:** asserted from cycle N+1 until the edge that returns the FSM to WAIT.

## Test plan
- **Reset mid-RUN:** issue a request, then assert `reset` for 1 cycle while in RUN → next cycle `start`=0, `busy`=0, `count`=0, `req_ready`=1, `abort`=0, `drop_cnt`=0.
- **Back-to-back issue:** push 0xA1, 0xB2, 0xC3 on consecutive cycles, with `fsm_state` driven by a model controller.
  - Required: three `start` pulses spaced exactly 4 cycles apart.
  - Required: `load_data`=0xA1, then 0xB2, then 0xC3, each valid during the matching LOAD cycle.
  - Required: `count` ends at 0.
- **Overflow:** with `fsm_state` held at 01, push 6 words into DEPTH=4 → `count`=4, `req_ready`=0, `drop_cnt`=2, and no `start` pulse. Then release the controller → the 4 stored words issue in FIFO order.
- **Simultaneous push and pop:** push while the FIFO is full → refused. Push at an issue edge with 1 entry stored → `count` stays 1.
- **ACK timeout:** issue a request, then hold `fsm_state` at 00 → after 4 edges the FSM is in WAIT with `abort`=1 and the entry consumed. A later request still issues normally.
- **Controller reset in RUN:** force `fsm_state` 01→00 with no DONE → `abort`=1, `busy` drops, and the next queued request issues at the following edge.
